// File: rtl/alu_mc.sv
// Multi-cycle handshaked ALU with registered result and flags.
// Define ALU_MC_MUL_EN to build the iterative shift-add multiplier (opcode 12).
module alu_mc #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    input  logic                 carry_in,
    input  logic [3:0]           opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] y,
    output logic [BUS_WIDTH-1:0] y_hi,
    output logic                 carry_out,
    output logic                 borrow,
    output logic                 zero,
    output logic                 parity,
    output logic                 invalid_op
);
    localparam int BW = BUS_WIDTH;
    localparam int RW = $clog2(BUS_WIDTH);

    localparam logic [3:0] OP_ADD = 4'd1, OP_ADC = 4'd2, OP_SUB = 4'd3, OP_INC = 4'd4,
                           OP_DEC = 4'd5, OP_AND = 4'd6, OP_NOT = 4'd7, OP_ROL = 4'd8,
                           OP_ROR = 4'd9, OP_OR  = 4'd10, OP_XOR = 4'd11;

`ifdef ALU_MC_MUL_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

    state_t state_q, state_d;
    logic   accept, is_mul;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;

    // Single-cycle datapath evaluated on the live inputs; only latched on accept.
    logic [BW-1:0]   r_y;
    logic            r_c, r_bw, r_inv;
    logic [2*BW-1:0] rol_t, ror_t;
    logic [RW-1:0]   amt;

    assign amt   = b[RW-1:0];
    assign rol_t = {a, a} << amt;
    assign ror_t = {a, a} >> amt;

    always_comb begin
        r_y   = '0;
        r_c   = 1'b0;
        r_bw  = 1'b0;
        r_inv = 1'b0;
        case (opcode)
            OP_ADD: r_y = a + b;
            OP_ADC: {r_c, r_y}  = {1'b0, a} + {1'b0, b} + {{BW{1'b0}}, carry_in};
            OP_SUB: {r_bw, r_y} = {1'b0, a} - {1'b0, b};
            OP_INC: {r_c, r_y}  = {1'b0, a} + {{BW{1'b0}}, 1'b1};
            OP_DEC: {r_bw, r_y} = {1'b0, a} - {{BW{1'b0}}, 1'b1};
            OP_AND: r_y = a & b;
            OP_NOT: r_y = ~a;
            OP_ROL: r_y = rol_t[2*BW-1:BW];
            OP_ROR: r_y = ror_t[BW-1:0];
            OP_OR:  r_y = a | b;
            OP_XOR: r_y = a ^ b;
            default: r_inv = 1'b1;
        endcase
    end

`ifdef ALU_MC_MUL_EN
    localparam logic [RW:0] CNT_LAST = (RW+1)'(BUS_WIDTH);
    logic [BW-1:0]   mcand;
    logic [2*BW-1:0] prod;
    logic [RW:0]     cnt;
    logic [BW:0]     psum;
    logic [BW-1:0]   y_hi_q;

    assign is_mul = (opcode == 4'd12);
    // Upper half accumulates the multiplicand when the current multiplier bit is set.
    assign psum   = {1'b0, prod[2*BW-1:BW]} + (prod[0] ? {1'b0, mcand} : {(BW+1){1'b0}});
    assign y_hi   = y_hi_q;
`else
    assign is_mul = 1'b0;
    assign y_hi   = '0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = is_mul ? state_t'(1) : DONE;
`ifdef ALU_MC_MUL_EN
            BUSY: if (cnt == CNT_LAST) state_d = DONE;
`endif
            DONE: if (out_ready) state_d = in_valid ? (is_mul ? state_t'(1) : DONE) : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            y          <= '0;
            carry_out  <= 1'b0;
            borrow     <= 1'b0;
            zero       <= 1'b0;
            parity     <= 1'b0;
            invalid_op <= 1'b0;
`ifdef ALU_MC_MUL_EN
            y_hi_q     <= '0;
            mcand      <= '0;
            prod       <= '0;
            cnt        <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept && !is_mul) begin
                y          <= r_y;
                carry_out  <= r_c;
                borrow     <= r_bw;
                zero       <= (r_y == '0);
                parity     <= ^r_y;
                invalid_op <= r_inv;
`ifdef ALU_MC_MUL_EN
                y_hi_q     <= '0;
`endif
            end
`ifdef ALU_MC_MUL_EN
            if (accept && is_mul) begin
                mcand <= a;
                prod  <= {{BW{1'b0}}, b};
                cnt   <= '0;
            end else if (state_q == BUSY) begin
                if (cnt != CNT_LAST) begin
                    prod <= {psum, prod[BW-1:1]};
                    cnt  <= cnt + 1'b1;
                end else begin
                    // Extra commit cycle gives the BW+1 accept-to-valid latency.
                    y          <= prod[BW-1:0];
                    y_hi_q     <= prod[2*BW-1:BW];
                    carry_out  <= |prod[2*BW-1:BW];
                    borrow     <= 1'b0;
                    zero       <= (prod[BW-1:0] == '0);
                    parity     <= ^prod[BW-1:0];
                    invalid_op <= 1'b0;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc at BUS_WIDTH=8; covers both builds of ALU_MC_MUL_EN.
module tb_alu_mc;
    localparam int BW = 8;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, carry_in, out_valid, out_ready;
    logic carry_out, borrow, zero, parity, invalid_op;
    logic [BW-1:0] a, b, y, y_hi;
    logic [3:0] opcode;
    int n_vec = 0, n_err = 0;

    alu_mc #(.BUS_WIDTH(BW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .carry_in(carry_in), .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .y_hi(y_hi),
        .carry_out(carry_out), .borrow(borrow), .zero(zero), .parity(parity),
        .invalid_op(invalid_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] aa, input logic [7:0] bb,
                         input logic ci);
        opcode = op; a = aa; b = bb; carry_in = ci; in_valid = 1'b1;
        step();
        // Scramble inputs after accept; the captured op must not see them.
        in_valid = 1'b0; a = ~aa; b = ~bb; opcode = 4'hF; carry_in = ~ci;
    endtask

    task automatic res(input string tag, input logic [7:0] ey, input logic [7:0] ehi,
                       input logic ec, input logic eb, input logic ez, input logic ep,
                       input logic ei);
        chk({tag, ".out_valid"}, out_valid, 1);
        chk({tag, ".y"}, y, ey);
        chk({tag, ".y_hi"}, y_hi, ehi);
        chk({tag, ".carry_out"}, carry_out, ec);
        chk({tag, ".borrow"}, borrow, eb);
        chk({tag, ".zero"}, zero, ez);
        chk({tag, ".parity"}, parity, ep);
        chk({tag, ".invalid_op"}, invalid_op, ei);
    endtask

    initial begin
        int cyc;
        logic seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        carry_in = 1'b0; opcode = '0;
        step(); step();
        chk("rst.out_valid", out_valid, 0);
        chk("rst.y", y, 0);
        chk("rst.y_hi", y_hi, 0);
        chk("rst.flags", {carry_out, borrow, zero, parity, invalid_op}, 0);
        rst = 1'b0;
        step();
        chk("rst.in_ready", in_ready, 1);
        chk("rst.idle_out_valid", out_valid, 0);

        out_ready = 1'b1;
        issue(4'd2, 8'hFF, 8'h01, 1'b1); res("adc",  8'h01, 0, 1, 0, 0, 1, 0);
        issue(4'd3, 8'h03, 8'h05, 1'b0); res("sub",  8'hFE, 0, 0, 1, 0, 1, 0);
        issue(4'd8, 8'h81, 8'h03, 1'b0); res("rol",  8'h0C, 0, 0, 0, 0, 0, 0);
        issue(4'd9, 8'h81, 8'h0B, 1'b0); res("ror",  8'h30, 0, 0, 0, 0, 0, 0);
        issue(4'd0, 8'h12, 8'h34, 1'b1); res("op0",  8'h00, 0, 0, 0, 1, 0, 1);
        issue(4'd1, 8'hFF, 8'h01, 1'b1); res("add",  8'h00, 0, 0, 0, 1, 0, 0);
        issue(4'd4, 8'hFF, 8'h00, 1'b0); res("inc",  8'h00, 0, 1, 0, 1, 0, 0);
        issue(4'd5, 8'h00, 8'h00, 1'b0); res("dec",  8'hFF, 0, 0, 1, 0, 0, 0);
        issue(4'd6, 8'hF0, 8'h3C, 1'b0); res("and",  8'h30, 0, 0, 0, 0, 0, 0);
        issue(4'd7, 8'h5A, 8'h00, 1'b0); res("not",  8'hA5, 0, 0, 0, 0, 0, 0);
        issue(4'd10, 8'hF0, 8'h0E, 1'b0); res("or",  8'hFE, 0, 0, 0, 0, 1, 0);
        issue(4'd11, 8'hFF, 8'h0F, 1'b0); res("xor", 8'hF0, 0, 0, 0, 0, 0, 0);
        issue(4'd13, 8'h01, 8'h01, 1'b0); res("op13", 8'h00, 0, 0, 0, 1, 0, 1);

`ifdef ALU_MC_MUL_EN
        issue(4'd12, 8'hFF, 8'hFF, 1'b0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            chk("mul.busy_in_ready", in_ready, 0);
            step();
            cyc++;
        end
        chk("mul.latency", cyc, 9);
        res("mul", 8'h01, 8'hFE, 1, 0, 0, 1, 0);
        issue(4'd12, 8'h0D, 8'h0B, 1'b0);
        repeat (9) step();
        res("mul2", 8'h8F, 8'h00, 0, 0, 0, 1, 0);
`else
        issue(4'd12, 8'hFF, 8'hFF, 1'b0); res("mul_off", 8'h00, 0, 0, 0, 1, 0, 1);
`endif

        // Drain, then hold the ADD result under backpressure with a pending op.
        step();
        out_ready = 1'b0;
        issue(4'd1, 8'h10, 8'h20, 1'b0);
        opcode = 4'd11; a = 8'h0F; b = 8'h03; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp.out_valid", out_valid, 1);
            chk("bp.y", y, 8'h30);
            chk("bp.in_ready", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        res("bp.next", 8'h0C, 0, 0, 0, 0, 0, 0);

`ifdef ALU_MC_MUL_EN
        issue(4'd12, 8'h12, 8'h34, 1'b0);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rmul.out_valid", out_valid, 0);
        chk("rmul.y", y, 0);
        chk("rmul.y_hi", y_hi, 0);
        chk("rmul.in_ready", in_ready, 1);
        seen = 1'b0;
        repeat (12) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("rmul.no_result", seen, 0);
`endif

        step();
        out_ready = 1'b0;
        issue(4'd1, 8'h10, 8'h20, 1'b0);
        chk("rdone.pre_valid", out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rdone.out_valid", out_valid, 0);
        chk("rdone.y", y, 0);
        chk("rdone.zero", zero, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
